mul_div_sequencer: RTL
======================

// Module: mul_div_sequencer
// PURPOSE
//  Multi-cycle MULT/MULTU/DIV/DIVU unit and owner of the architectural HI/LO registers.
//  Sits beside the 32-bit carry-lookahead adder in the EX stage. It drives the adder
//  operands every iteration and consumes the sum. The pipeline stalls on busy.
//  Iterative shift-add multiply and restoring divide use exactly one adder pass per cycle.
// PARAMETERS
//  WIDTH   32  operand width; only 32 is supported
//  CNT_W   6   iteration counter width (holds 0..WIDTH)
// PORTS
//  clk      in   1   single clock, rising edge
//  reset    in   1   synchronous, active-high
//  start    in   1   launch operation; sampled only when busy=0
//  op       in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU; latched with start
//  rs       in   32  multiplicand / dividend; latched with start
//  rt       in   32  multiplier / divisor; latched with start
//  hi_we    in   1   MTHI write strobe
//  lo_we    in   1   MTLO write strobe
//  wdata    in   32  MTHI/MTLO data
//  add_a    out  32  to adder A
//  add_b    out  32  to adder B
//  add_cin  out  1   to adder cin
//  add_s    in   32  from adder S (combinational, same cycle)
//  busy     out  1   operation in flight
//  done     out  1   one-cycle pulse: HI/LO hold the new result
//  hi       out  32  HI register
//  lo       out  32  LO register
// BEHAVIOUR
//  Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, count=0, add_a/add_b=0, add_cin=0.
//  FSM: IDLE -start-> PREP -> ITER (32 cycles) -> FIX -> IDLE.
//   Edge 0 samples start. Edges 1 (PREP), 2..33 (ITER) and 34 (FIX) follow.
//   busy=1 after edge 0 through edge 34. done=1 for exactly the cycle after edge 34.
//   hi/lo take the result at edge 34.
//  PREP:
//   Latch magnitudes |rs| and |rt|. Signed ops use internal two's-complement negation;
//   unsigned ops use the raw values.
//   Record neg_q = rs[31]^rt[31] and neg_r = rs[31] for signed ops; both are 0 for unsigned.
//  Adder carry-out (the adder exposes none): cout = (a31&b31) | ((a31^b31) & ~s31).
//  ITER, multiply: registers {c, P_hi, P_lo}, with P_lo initialised to |rt| and P_hi to 0.
//   add_a=P_hi, add_b = P_lo[0] ? |rs| : 0, add_cin=0.
//   Next {c, P_hi, P_lo} = {0, cout, add_s, P_lo} >> 1.
//  ITER, divide: restoring. Registers R (32-bit remainder) and Q, with Q initialised to |rs|.
//   Shift {t, R', Q'} = {R, Q} << 1, where t is the bit shifted out of R.
//   add_a=R', add_b=~|rt|, add_cin=1.
//   If t|cout: R=add_s and Q'[0]=1. Else R=R' and Q'[0]=0.
//  FIX:
//   Multiply: if neg_q, negate the 64-bit product. hi=upper 32, lo=lower 32.
//   Divide: lo = neg_q ? -Q : Q. hi = neg_r ? -R : R.
//   Divide by zero (rt==0, either op): no sign fix. lo=32'hFFFF_FFFF, hi=rs as latched.
//   DIV 0x8000_0000 / -1: lo=0x8000_0000, hi=0; no exception.
//  start while busy=1 is ignored; operands are not re-latched.
//  hi_we/lo_we: write at the next edge when busy=0. Ignored while busy=1.
//  In IDLE, start and hi_we/lo_we may coincide: the write occurs, then FIX overwrites it.
//  FIX has priority over nothing else; done never coincides with busy=1.
//  reset mid-operation: abort at that edge. Reset values apply and no done is produced.
//  Outside ITER, add_a/add_b/add_cin are driven 0.
//  All outputs are registered except add_a, add_b and add_cin.
// TESTING
//  Bench instantiates this block with the team's 32-bit CLA adder on the add_* ports.
//  MULTU FFFF_FFFF*FFFF_FFFF -> hi=FFFF_FFFE, lo=0000_0001, done exactly 35 cycles after start.
//  MULT -3*7 -> hi=FFFF_FFFF, lo=FFFF_FFEB. MULT 8000_0000*8000_0000 -> hi=4000_0000, lo=0.
//  DIV -7/2 -> lo=FFFF_FFFD, hi=FFFF_FFFF. DIVU 100/7 -> lo=0x0E, hi=0x02.
//  DIVU 0x1234/0 -> lo=FFFF_FFFF, hi=0x1234.
//  DIV 8000_0000/FFFF_FFFF -> lo=8000_0000, hi=0.
//  Reset at ITER count 10 -> next cycle busy=0, hi=lo=0, no done.
//  Second start while busy is ignored: a single done with the first result.
//  hi_we=1, wdata=0xCAFE while busy -> hi unchanged.
//  Same write while idle -> hi=0xCAFE next cycle.
//  Random regression of 10k ops per opcode against a 64-bit reference model.

Source files
------------

// File: rtl/mul_div_sequencer.sv
// ---------------------------------------------------------------------------
// mul_div_sequencer
//   Multi-cycle MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
//   It borrows the EX-stage 32-bit adder for one pass per iteration. Multiply
//   is shift-add and divide is restoring. Both work on operand magnitudes,
//   and the sign is applied in the final FIX cycle.
//
//   Timeline:  IDLE -start-> PREP -> ITER x32 -> FIX -> IDLE
//              busy is high from the start edge until the FIX edge.
//              done pulses for one cycle once HI/LO hold the result.
//
// Ports
//   clk, reset          : clock and synchronous active-high reset
//   start, op, rs, rt   : launch request. op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   hi_we, lo_we, wdata : MTHI/MTLO writes, accepted only while idle
//   add_a, add_b, add_cin / add_s : operands to and sum from the shared adder
//   busy, done          : operation in flight / result-ready pulse
//   hi, lo              : architectural HI/LO registers
// ---------------------------------------------------------------------------
module mul_div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               is_div_q, is_div_d;
    logic               is_signed_q, is_signed_d;
    logic [WIDTH-1:0]   rs_q, rs_d;          // raw operands, latched with start
    logic [WIDTH-1:0]   rt_q, rt_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;    // |rs|
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;    // |rt|
    logic               quot_neg_q, quot_neg_d;
    logic               rem_neg_q, rem_neg_d;
    // Multiply: {acc_hi, acc_lo} = P_hi:P_lo. Divide: acc_hi = R and acc_lo = Q.
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;

    logic               cout;
    logic [WIDTH-1:0]   rem_shift;
    logic               rem_top;
    logic [2*WIDTH-1:0] product;

    // Adder operands are driven only during ITER and are zero otherwise.
    always_comb begin
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        rem_top   = acc_hi_q[WIDTH-1];
        rem_shift = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
        if (state_q == S_ITER) begin
            if (is_div_q) begin
                // Trial subtraction R' - |rt| as R' + ~|rt| + 1.
                add_a   = rem_shift;
                add_b   = ~mag_b_q;
                add_cin = 1'b1;
            end else begin
                add_a   = acc_hi_q;
                add_b   = acc_lo_q[0] ? mag_a_q : '0;
            end
        end
    end

    // The adder exposes no carry-out, so it is recovered from the MSBs.
    assign cout = (add_a[WIDTH-1] & add_b[WIDTH-1]) |
                  ((add_a[WIDTH-1] ^ add_b[WIDTH-1]) & ~add_s[WIDTH-1]);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        count_d     = count_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        quot_neg_d  = quot_neg_q;
        rem_neg_d   = rem_neg_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        product     = {acc_hi_q, acc_lo_q};

        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d     = S_PREP;
                    busy_d      = 1'b1;
                    is_div_d    = op[1];
                    is_signed_d = ~op[0];
                    rs_d        = rs;
                    rt_d        = rt;
                end
            end

            S_PREP: begin
                mag_a_d    = (is_signed_q && rs_q[WIDTH-1]) ? -rs_q : rs_q;
                mag_b_d    = (is_signed_q && rt_q[WIDTH-1]) ? -rt_q : rt_q;
                quot_neg_d = is_signed_q & (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
                rem_neg_d  = is_signed_q & rs_q[WIDTH-1];
                acc_hi_d   = '0;
                acc_lo_d   = is_div_q ? mag_a_d : mag_b_d;
                count_d    = '0;
                state_d    = S_ITER;
            end

            S_ITER: begin
                count_d = count_q + 1'b1;
                if (is_div_q) begin
                    // A bit shifted out of R means R' >= 2^32 > |rt|, so the subtraction always succeeds.
                    if (rem_top | cout) begin
                        acc_hi_d = add_s;
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = rem_shift;
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = {cout, add_s[WIDTH-1:1]};
                    acc_lo_d = {add_s[0], acc_lo_q[WIDTH-1:1]};
                end
                if (count_q == LAST_ITER) state_d = S_FIX;
            end

            S_FIX: begin
                if (!is_div_q) begin
                    if (quot_neg_q) product = -product;
                    hi_d = product[2*WIDTH-1:WIDTH];
                    lo_d = product[WIDTH-1:0];
                end else if (mag_b_q == '0) begin
                    // Divide by zero returns an all-ones quotient and the raw dividend.
                    lo_d = '1;
                    hi_d = rs_q;
                end else begin
                    lo_d = quot_neg_q ? -acc_lo_q : acc_lo_q;
                    hi_d = rem_neg_q  ? -acc_hi_q : acc_hi_q;
                end
                count_d = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            count_q     <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            quot_neg_q  <= 1'b0;
            rem_neg_q   <= 1'b0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            count_q     <= count_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            quot_neg_q  <= quot_neg_d;
            rem_neg_q   <= rem_neg_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
